// File: rtl/parallel_pe_pkg.sv
// Shared definitions for the parallel_pe dot-product engine: lane geometry,
// accumulator width and the beat-control encodings.
package parallel_pe_pkg;

  localparam int unsigned LANES  = 32;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 32;

  typedef enum logic [1:0] {
    CTL_MID    = 2'b00,
    CTL_FIRST  = 2'b01,
    CTL_LAST   = 2'b10,
    CTL_SINGLE = 2'b11
  } ctl_e;

  // A beat that opens a sequence discards the running sum.
  function automatic logic ctl_starts(input ctl_e c);
    return (c == CTL_FIRST) || (c == CTL_SINGLE);
  endfunction

  // A beat that closes a sequence publishes the running sum.
  function automatic logic ctl_ends(input ctl_e c);
    return (c == CTL_LAST) || (c == CTL_SINGLE);
  endfunction

endpackage

// File: rtl/pe_dot32.sv
// Purely combinational 32-lane signed 16x16 multiplier array followed by a
// balanced adder tree. The sum wraps modulo 2^ACC_W.
module pe_dot32
  import parallel_pe_pkg::*;
(
  input  logic [LANES*DATA_W-1:0] neuron,
  input  logic [LANES*DATA_W-1:0] weight,
  output logic [ACC_W-1:0]        dot
);

  // Multiply every lane, then reduce pairwise; tree is stored heap-style with
  // leaves at [LANES-1 .. 2*LANES-2] and the root at index 0.
  always_comb begin
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic signed [ACC_W-1:0]  tree [2*LANES-1];
    a    = '0;
    b    = '0;
    tree = '{default: '0};
    for (int unsigned i = 0; i < LANES; i++) begin
      a = neuron[i*DATA_W +: DATA_W];
      b = weight[i*DATA_W +: DATA_W];
      tree[LANES-1+i] = ACC_W'(a) * ACC_W'(b);
    end
    for (int unsigned k = LANES - 1; k > 0; k--) begin
      tree[k-1] = tree[2*k-1] + tree[2*k];
    end
    dot = tree[0];
  end

endmodule

// File: rtl/parallel_pe.sv
// parallel_pe: 32-lane signed dot-product engine with a multi-beat
// accumulator. Optional macro PARALLEL_PE_PIPE_EN inserts a register stage
// between the adder tree and the accumulator (latency 2 instead of 1).
module parallel_pe
  import parallel_pe_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*DATA_W-1:0] neuron,
  input  logic [LANES*DATA_W-1:0] weight,
  input  logic [1:0]              ctl,
  input  logic                    vld_i,
  output logic [ACC_W-1:0]        result,
  output logic                    vld_o
);

  logic [ACC_W-1:0] dot_c;
  logic [ACC_W-1:0] acc_dot;
  logic             acc_vld;
  ctl_e             acc_ctl;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_nxt;

  pe_dot32 u_dot (
    .neuron (neuron),
    .weight (weight),
    .dot    (dot_c)
  );

`ifdef PARALLEL_PE_PIPE_EN
  logic [ACC_W-1:0] dot_q;
  logic             vld_q;
  ctl_e             ctl_q;

  // Pipeline stage: capture the tree sum with its beat control and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_q <= '0;
      vld_q <= 1'b0;
      ctl_q <= CTL_MID;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        dot_q <= dot_c;
        ctl_q <= ctl_e'(ctl);
      end
    end
  end

  assign acc_dot = dot_q;
  assign acc_vld = vld_q;
  assign acc_ctl = ctl_q;
`else
  assign acc_dot = dot_c;
  assign acc_vld = vld_i;
  assign acc_ctl = ctl_e'(ctl);
`endif

  // Next accumulator value: restart on an opening beat, otherwise add on.
  always_comb begin
    acc_nxt = ctl_starts(acc_ctl) ? acc_dot : acc_q + acc_dot;
  end

  // Accumulator, published result and one-cycle output valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      result <= '0;
      vld_o  <= 1'b0;
    end else begin
      vld_o <= acc_vld && ctl_ends(acc_ctl);
      if (acc_vld) begin
        acc_q <= acc_nxt;
        if (ctl_ends(acc_ctl)) begin
          result <= acc_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_parallel_pe.sv
// Table-driven bench for parallel_pe with a result scoreboard.
module tb_parallel_pe;

`ifdef PARALLEL_PE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] neuron = '0;
  logic [511:0] weight = '0;
  logic [1:0]   ctl = 2'b00;
  logic         vld_i = 1'b0;
  logic [31:0]  result;
  logic         vld_o;

  parallel_pe dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .neuron (neuron),
    .weight (weight),
    .ctl    (ctl),
    .vld_i  (vld_i),
    .result (result),
    .vld_o  (vld_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] n;
    logic [511:0] w;
    logic [1:0]   c;
    logic         v;
    logic [31:0]  exp;
  } row_t;

  typedef struct {
    logic [31:0] res;
    int          due;
  } sb_t;

  row_t        tbl[$];
  sb_t         sb[$];
  logic [31:0] m_acc = '0;
  logic [31:0] held = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dot_model(input logic [511:0] n, input logic [511:0] w);
    logic [31:0]        s;
    logic signed [31:0] a32;
    logic signed [31:0] b32;
    s = '0;
    for (int i = 0; i < 32; i++) begin
      a32 = {{16{n[16*i+15]}}, n[16*i +: 16]};
      b32 = {{16{w[16*i+15]}}, w[16*i +: 16]};
      s = s + 32'(a32 * b32);
    end
    return s;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] fill(input logic [15:0] v);
    return {32{v}};
  endfunction

  // Append one beat; the golden accumulator supplies the expectation unless
  // a fixed constant is given.
  task automatic add_row(input logic [511:0] n, input logic [511:0] w,
                         input logic [1:0] c, input logic v,
                         input logic use_k, input logic [31:0] k);
    row_t r;
    r.n = n; r.w = w; r.c = c; r.v = v;
    if (v) begin
      if (c[0]) m_acc = dot_model(n, w);
      else      m_acc = m_acc + dot_model(n, w);
    end
    r.exp = use_k ? k : m_acc;
    tbl.push_back(r);
  endtask

  task automatic add_gap();
    add_row(rnd512(), rnd512(), 2'($urandom_range(0, 3)), 1'b0, 1'b0, '0);
  endtask

  task automatic drive_row(input row_t r);
    sb_t e;
    @(negedge clk);
    neuron = r.n;
    weight = r.w;
    ctl    = r.c;
    vld_i  = r.v;
    if (r.v && r.c[1]) begin
      e.res = r.exp;
      e.due = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Output monitor: every pulse must match the scoreboard head in value and
  // timing; between pulses result must hold and no pulse may be overdue.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && mon_en) begin
      if (vld_o) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_vld_o: vld_o=1 at cycle %0d expected 0", cyc);
        end else begin
          e = sb.pop_front();
          if (result !== e.res || cyc != e.due) begin
            n_bad++;
            $display("FAIL pulse: result %h at cycle %0d expected %h at cycle %0d",
                     result, cyc, e.res, e.due);
          end
          held = e.res;
        end
      end else begin
        n_cmp++;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          n_bad++;
          $display("FAIL missing_vld_o: vld_o=0 at cycle %0d expected 1", cyc);
          held = e.res;
        end
        check("result_hold", result, held);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] t0;
    logic [511:0] t1;
    row_t         r;

    // Stimulus table
    add_row(fill(16'd1), fill(16'd2), 2'b01, 1'b1, 1'b0, '0);
    add_row(fill(16'd1), fill(16'd2), 2'b00, 1'b1, 1'b0, '0);
    add_row(fill(16'd1), fill(16'd2), 2'b00, 1'b1, 1'b0, '0);
    add_row(fill(16'd1), fill(16'd2), 2'b10, 1'b1, 1'b1, 32'd256);
    add_gap();
    t0 = '0; t0[15:0] = 16'hFFFF;
    t1 = '0; t1[15:0] = 16'd3;
    add_row(t0, t1, 2'b11, 1'b1, 1'b1, 32'hFFFF_FFFD);
    add_gap();
    add_row(fill(16'h7FFF), fill(16'h7FFF), 2'b11, 1'b1, 1'b1, 32'hFFE0_0020);
    // last beat with no opening beat adds onto the held accumulator
    add_row(rnd512(), rnd512(), 2'b10, 1'b1, 1'b0, '0);
    add_gap();
    // restart mid-sequence
    add_row(rnd512(), rnd512(), 2'b01, 1'b1, 1'b0, '0);
    add_row(rnd512(), rnd512(), 2'b00, 1'b1, 1'b0, '0);
    add_row(rnd512(), rnd512(), 2'b01, 1'b1, 1'b0, '0);
    add_row(rnd512(), rnd512(), 2'b10, 1'b1, 1'b0, '0);
    // back-to-back with no idle cycles
    add_row(rnd512(), rnd512(), 2'b11, 1'b1, 1'b0, '0);
    add_row(rnd512(), rnd512(), 2'b11, 1'b1, 1'b0, '0);
    add_row(rnd512(), rnd512(), 2'b01, 1'b1, 1'b0, '0);
    add_row(rnd512(), rnd512(), 2'b10, 1'b1, 1'b0, '0);
    add_row(rnd512(), rnd512(), 2'b01, 1'b1, 1'b0, '0);
    add_row(rnd512(), rnd512(), 2'b10, 1'b1, 1'b0, '0);
    add_gap();
    // four 4-beat sequences separated by one idle cycle
    for (int s = 0; s < 4; s++) begin
      add_row(rnd512(), rnd512(), 2'b01, 1'b1, 1'b0, '0);
      add_row(rnd512(), rnd512(), 2'b00, 1'b1, 1'b0, '0);
      add_row(rnd512(), rnd512(), 2'b00, 1'b1, 1'b0, '0);
      add_row(rnd512(), rnd512(), 2'b10, 1'b1, 1'b0, '0);
      add_gap();
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_vld_o", {31'b0, vld_o}, 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive_row(tbl[i]);
    end
    @(negedge clk);
    vld_i = 1'b0;
    repeat (LAT + 3) @(negedge clk);

    // Reset in the middle of a sequence
    r.n = rnd512(); r.w = rnd512(); r.c = 2'b01; r.v = 1'b1; r.exp = '0;
    drive_row(r);
    r.n = rnd512(); r.w = rnd512(); r.c = 2'b00;
    drive_row(r);
    @(negedge clk);
    vld_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midseq_reset_result", result, 32'h0);
    check("midseq_reset_vld_o", {31'b0, vld_o}, 32'h0);
    held = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r.n = fill(16'd1); r.w = fill(16'd1); r.c = 2'b01; r.v = 1'b1; r.exp = '0;
    drive_row(r);
    r.c = 2'b10; r.exp = 32'd64;
    drive_row(r);
    @(negedge clk);
    vld_i = 1'b0;

    // Drain with a bounded wait
    for (int k = 0; k < LAT + 4 && sb.size() > 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
